tsp_key_sequencer: RTL
======================

TSP_KEY_SEQUENCER -- requirements
Module: tsp_key_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 64: pattern buffer entries, which is also the maximum pattern length.
REQ-002 SHALL have parameter LOG2_NPE, default 15: match_count width.
REQ-003 SHALL have parameter TIMEOUT, default 65535: maximum number of WAIT_RES cycles.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have pattern stream inputs: pat_valid (in, 1), pat_ready (out, 1), pat_byte (in, 8), pat_mask (in, 1), pat_gap_begin (in, 1), pat_gap_end (in, 1), pat_last (in, 1).
REQ-007 SHALL have config inputs: cfg_byte_mode (in, 2) and cfg_overlap (in, 1).
REQ-008 SHALL have abort (in, 1): synchronous return to IDLE.
REQ-009 SHALL have matcher-facing outputs: start, key (8), byte_mode (2), last_byte, mask, begin_gap, end_gap, overlap, key_length (9).
REQ-010 SHALL have matcher result inputs: match_count (LOG2_NPE) and match_count_valid (1).
REQ-011 SHALL have status outputs:
- busy (1)
- last_match_count (LOG2_NPE)
- pattern_count (32)
- err_overflow (1)
- err_timeout (1)

Function
REQ-012 SHALL implement a state machine with states IDLE, LOAD, ISSUE and WAIT_RES.
REQ-013 SHALL drive pat_ready=1 exactly in IDLE and LOAD.
REQ-014 SHALL accept a byte on pat_valid&pat_ready and write {byte, mask, gap_begin, gap_end} to buffer[wr_ptr].
REQ-015 SHALL transition IDLE->LOAD on the first accepted byte that has pat_last=0.
REQ-016 SHALL transition IDLE or LOAD->ISSUE in the cycle after a byte with pat_last=1 is accepted.
REQ-017 SHALL, on the DEPTH-th accepted byte without pat_last, force the transition to ISSUE, treat that byte as the last, and set sticky err_overflow.
REQ-018 SHALL latch length=wr_ptr+1 (range 1..DEPTH), cfg_byte_mode and cfg_overlap on the transition into ISSUE, and hold them until the next ISSUE.
REQ-019 SHALL, in ISSUE, present one buffer entry per cycle in order 0..length-1, with all matcher outputs registered.
REQ-020 SHALL assert start only with entry 0 and last_byte only with entry length-1.
REQ-021 SHALL assert both start and last_byte in the same cycle when length=1.
REQ-022 SHALL present key_length=length, byte_mode and overlap stable from the start cycle through the last_byte cycle.
REQ-023 SHALL drive mask, begin_gap and end_gap equal to the stored flags of the entry being presented, and 0 outside ISSUE.
REQ-024 SHALL drive key=0 and start=last_byte=0 outside ISSUE.
REQ-025 SHALL transition ISSUE->WAIT_RES in the cycle after last_byte; the ISSUE duration is exactly length cycles.
REQ-026 SHALL, in WAIT_RES, on match_count_valid:
- capture match_count into last_match_count;
- increment pattern_count, wrapping at 2^32;
- transition to IDLE.
REQ-027 SHALL, in WAIT_RES, count cycles and, when TIMEOUT cycles elapse without match_count_valid, set sticky err_timeout, leave pattern_count unchanged and transition to IDLE.
REQ-028 SHALL ignore match_count_valid outside WAIT_RES.
REQ-029 SHALL, on abort (any state), in the next cycle:
- enter IDLE;
- clear wr_ptr and the timeout counter;
- deassert all matcher outputs.
REQ-030 SHALL give abort priority over every other transition, including a simultaneous match_count_valid; that match_count_valid is not counted.
REQ-031 SHALL keep err_overflow and err_timeout set until reset; abort does not clear them.
REQ-032 SHALL drive busy=1 in any state other than IDLE.

Reset
REQ-033 SHALL, on reset, enter IDLE and clear wr_ptr, rd_ptr, the timeout counter and all outputs:
- start, last_byte, mask, begin_gap, end_gap, overlap = 0;
- key, byte_mode, key_length = 0;
- last_match_count = 0, pattern_count = 0;
- err_* = 0, busy = 0.
REQ-034 SHALL, on reset asserted mid-ISSUE, drop start/last_byte within the reset assertion with no further bytes issued.
REQ-035 SHALL NOT reset buffer contents.

Structure
REQ-036 SHALL place state encoding constants (IDLE=0, LOAD=1, ISSUE=2, WAIT_RES=3) and byte-mode constants MODE_1B..MODE_4B (0..3) in the shared package tsp_pkg.
REQ-037 SHALL implement the buffer as one sub-module, tsp_pattern_buf: DEPTH x 11-bit, with registered read and a one-cycle read latency hidden by a prefetch at the LOAD->ISSUE transition.

Verification
REQ-038 SHALL verify a 3-byte pattern 0x41,0x42,0x43 (last on 0x43): ISSUE has start+key 0x41 at T, 0x42 at T+1, last_byte+key 0x43 at T+2, key_length=3.
REQ-039 SHALL verify a single byte 0x5A with pat_last: exactly one ISSUE cycle with start=last_byte=1, key=0x5A, key_length=1.
REQ-040 SHALL verify 64 bytes without pat_last: err_overflow=1, 64 bytes issued, last_byte on byte 64, pat_ready=0 during ISSUE.
REQ-041 SHALL verify that match_count_valid with match_count=7, 5 cycles after last_byte, gives last_match_count=7, pattern_count=1, busy=0 next cycle.
REQ-042 SHALL verify TIMEOUT=16 with no match_count_valid: err_timeout=1 after 16 WAIT_RES cycles, IDLE, pattern_count=0.
REQ-043 SHALL verify abort on the 2nd ISSUE cycle of a 5-byte pattern: outputs deasserted the next cycle, no last_byte seen, next pattern issues normally from entry 0.

Source files
------------

// File: rtl/tsp_pkg.sv
// Shared types and constants for the TSP key sequencer.
package tsp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    ISSUE    = 2'd2,
    WAIT_RES = 2'd3
  } state_e;

  localparam logic [1:0] MODE_1B = 2'd0;
  localparam logic [1:0] MODE_2B = 2'd1;
  localparam logic [1:0] MODE_3B = 2'd2;
  localparam logic [1:0] MODE_4B = 2'd3;

  // Buffer entry layout: {byte[7:0], mask, gap_begin, gap_end}
  localparam int ENTRY_W = 11;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [7:0] b,
                                                    input logic       m,
                                                    input logic       gb,
                                                    input logic       ge);
    return {b, m, gb, ge};
  endfunction

endpackage

// File: rtl/tsp_pattern_buf.sv
// Pattern storage: DEPTH x ENTRY_W, one write port, one registered read port.
// The read register returns zero when no read is requested, so its output can
// drive the matcher directly and is naturally idle outside ISSUE.
module tsp_pattern_buf
  import tsp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rd_data_d;
  logic [ENTRY_W-1:0] rd_data_q;

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read mux with write bypass: a one-byte pattern is written and prefetched on the same edge.
  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) rd_data_d = wr_data;
      else                               rd_data_d = mem_q[rd_addr];
    end
  end

  // Registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/tsp_key_sequencer.sv
// Collects a pattern byte stream into a buffer, replays it to the matcher one
// entry per cycle, then waits for the match count with a timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for the first pattern byte; pat_ready high
// LOAD     | collecting further pattern bytes; pat_ready high
// ISSUE    | replaying entries 0..length-1 to the matcher
// WAIT_RES | waiting for match_count_valid, timeout down-counter running
module tsp_key_sequencer
  import tsp_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int LOG2_NPE = 15,
  parameter int TIMEOUT  = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pat_valid,
  output logic                pat_ready,
  input  logic [7:0]          pat_byte,
  input  logic                pat_mask,
  input  logic                pat_gap_begin,
  input  logic                pat_gap_end,
  input  logic                pat_last,
  input  logic [1:0]          cfg_byte_mode,
  input  logic                cfg_overlap,
  input  logic                abort,
  output logic                start,
  output logic [7:0]          key,
  output logic [1:0]          byte_mode,
  output logic                last_byte,
  output logic                mask,
  output logic                begin_gap,
  output logic                end_gap,
  output logic                overlap,
  output logic [8:0]          key_length,
  input  logic [LOG2_NPE-1:0] match_count,
  input  logic                match_count_valid,
  output logic                busy,
  output logic [LOG2_NPE-1:0] last_match_count,
  output logic [31:0]         pattern_count,
  output logic                err_overflow,
  output logic                err_timeout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_INIT = TW'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [8:0]            rd_ptr_q, rd_ptr_d;   // index of the next entry to fetch
  logic [8:0]            length_q, length_d;
  logic [1:0]            mode_q, mode_d;
  logic                  ovl_q, ovl_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  start_q, start_d;
  logic                  last_q, last_d;
  logic [LOG2_NPE-1:0]   lmc_q, lmc_d;
  logic [31:0]           pcnt_q, pcnt_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_tmo_q, err_tmo_d;

  logic                  accept;
  logic                  buf_wr_en;
  logic                  buf_rd_en;
  logic [AW-1:0]         buf_rd_addr;
  logic [ENTRY_W-1:0]    buf_rd_data;

  assign pat_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept    = pat_valid && pat_ready;

  tsp_pattern_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (pack_entry(pat_byte, pat_mask, pat_gap_begin, pat_gap_end)),
    .rd_en   (buf_rd_en),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  // Next-state, pointer, timer and status logic; abort overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    length_d    = length_q;
    mode_d      = mode_q;
    ovl_d       = ovl_q;
    tmo_d       = tmo_q;
    start_d     = 1'b0;
    last_d      = 1'b0;
    lmc_d       = lmc_q;
    pcnt_d      = pcnt_q;
    err_ovf_d   = err_ovf_q;
    err_tmo_d   = err_tmo_q;
    buf_wr_en   = 1'b0;
    buf_rd_en   = 1'b0;
    buf_rd_addr = rd_ptr_q[AW-1:0];

    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          buf_wr_en = 1'b1;
          if (pat_last || (wr_ptr_q == AW'(DEPTH - 1))) begin
            // Prefetch entry 0 so it is on the outputs in the first ISSUE cycle.
            state_d     = ISSUE;
            length_d    = 9'(wr_ptr_q) + 9'd1;
            mode_d      = cfg_byte_mode;
            ovl_d       = cfg_overlap;
            wr_ptr_d    = '0;
            buf_rd_en   = 1'b1;
            buf_rd_addr = '0;
            rd_ptr_d    = 9'd1;
            start_d     = 1'b1;
            last_d      = (wr_ptr_q == '0);
            if (!pat_last) err_ovf_d = 1'b1;
          end else begin
            state_d  = LOAD;
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      ISSUE: begin
        if (rd_ptr_q == length_q) begin
          state_d  = WAIT_RES;
          rd_ptr_d = '0;
          tmo_d    = TMO_INIT;
        end else begin
          buf_rd_en = 1'b1;
          rd_ptr_d  = rd_ptr_q + 9'd1;
          last_d    = (rd_ptr_q == (length_q - 9'd1));
        end
      end
      WAIT_RES: begin
        if (match_count_valid) begin
          lmc_d   = match_count;
          pcnt_d  = pcnt_q + 32'd1;
          tmo_d   = '0;
          state_d = IDLE;
        end else if (tmo_q == '0) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      tmo_d     = '0;
      length_d  = length_q;
      mode_d    = mode_q;
      ovl_d     = ovl_q;
      start_d   = 1'b0;
      last_d    = 1'b0;
      lmc_d     = lmc_q;
      pcnt_d    = pcnt_q;
      err_ovf_d = err_ovf_q;
      err_tmo_d = err_tmo_q;
      buf_wr_en = 1'b0;
      buf_rd_en = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      length_q  <= '0;
      mode_q    <= '0;
      ovl_q     <= 1'b0;
      tmo_q     <= '0;
      start_q   <= 1'b0;
      last_q    <= 1'b0;
      lmc_q     <= '0;
      pcnt_q    <= '0;
      err_ovf_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      length_q  <= length_d;
      mode_q    <= mode_d;
      ovl_q     <= ovl_d;
      tmo_q     <= tmo_d;
      start_q   <= start_d;
      last_q    <= last_d;
      lmc_q     <= lmc_d;
      pcnt_q    <= pcnt_d;
      err_ovf_q <= err_ovf_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign start            = start_q;
  assign last_byte        = last_q;
  assign key              = buf_rd_data[10:3];
  assign mask             = buf_rd_data[2];
  assign begin_gap        = buf_rd_data[1];
  assign end_gap          = buf_rd_data[0];
  assign key_length       = length_q;
  assign byte_mode        = mode_q;
  assign overlap          = ovl_q;
  assign busy             = (state_q != IDLE);
  assign last_match_count = lmc_q;
  assign pattern_count    = pcnt_q;
  assign err_overflow     = err_ovf_q;
  assign err_timeout      = err_tmo_q;

endmodule
